rr_data_arbiter: RTL and testbench
==================================

Name: rr_data_arbiter

Overview:
- Round-robin arbiter that shares one registered data stage between NUM_REQ requesters.
- The shared stage is an output register with valid/ready handshake; the arbiter sequences which requester loads it each cycle.
- A granted requester may hold the stage for a burst of up to MAX_BURST consecutive beats before it must re-arbitrate.
- Sits between several producer blocks and a single downstream consumer, with a global enable gate.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH, 8, data width in bits.
- MAX_BURST, 4, max consecutive beats per grant (>=1).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset: asynchronous, active-low.
- enable  input  1  when low, no new beats are accepted; the output register still drains.
- req_valid  input  NUM_REQ  per-requester valid.
- req_data  input  NUM_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
- req_ready  output  NUM_REQ  one-hot accept strobe; bit i high means beat i is taken this cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_id  output  ID_W = max(1, clog2(NUM_REQ))  index of the requester that sourced out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_id=0.
  - FSM=IDLE, rr_ptr=0, owner=0, beat_cnt=0.
  - req_ready forced to all-zero while rst_n is low.
- Reset mid-operation: any held output beat is discarded; no partial state survives.
- Load condition:
  - can_load = enable && (!out_valid || out_ready).
  - At most one beat is accepted per cycle. req_ready[i]=1 only when i is the winner, req_valid[i]=1 and can_load=1.
  - req_ready is combinational from req_valid; producers must not make req_valid depend on req_ready.
- Latency and throughput: an accepted beat appears on out_valid/out_data/out_id the next cycle. Throughput is 1 beat/cycle with out_ready held high, with no bubbles between bursts.
- Output hold: while out_valid && !out_ready, out_data and out_id stay stable and req_ready is all-zero.
- FSM states: IDLE, LOCKED.
- IDLE:
  - If can_load and any req_valid: winner is the first requester with valid set, searching upward from rr_ptr with wrap-around.
  - Accept the winner's beat, set owner=winner, beat_cnt=1.
  - Go to LOCKED, unless MAX_BURST==1, in which case release immediately (see release).
- LOCKED:
  - If can_load and req_valid[owner] and beat_cnt<MAX_BURST: accept the owner's beat, beat_cnt++.
  - If beat_cnt reaches MAX_BURST on that accept: release.
  - If can_load and !req_valid[owner] (owner drops): release, and arbitrate the other requesters in the same cycle with no idle cycle.
  - If !can_load: hold owner and beat_cnt unchanged. Toggling enable does not forfeit the remaining burst budget.
- Release:
  - rr_ptr = (owner+1) mod NUM_REQ; FSM returns to IDLE.
  - On an owner-drop release, the same-cycle arbitration starts from the new rr_ptr. The previous owner has lowest priority and may win only if no one else is valid.
  - On a burst-limit release, the next beat is arbitrated the following cycle from the new rr_ptr.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Simultaneous events:
  - Output drain and new load in the same cycle is legal; the register takes the new beat.
  - Requests arriving while enable is low are ignored until enable rises; no state changes occur.

Test Plan:
1. Assert rst_n low mid-burst with out_valid=1 → out_valid=0, out_data=0, out_id=0 and req_ready=0 immediately. After release, the first grant goes to requester 0 if valid.
2. Only req 2 valid, data 0x11, 0x22, 0x33, 0x44, 0x55; out_ready=1; MAX_BURST=4 → out_data 0x11..0x44 with out_id=2 on consecutive cycles. The burst limit then releases, one rearbitration cycle follows, and req 2 wins 0x55.
3. All four requesters continuously valid, MAX_BURST=2, out_ready=1 → out_id sequence 0,0,1,1,2,2,3,3,0,0 with exactly one req_ready bit high per accept.
4. out_ready held low 3 cycles while out_valid=1 and out_data=0xA5 → out_data stays 0xA5 and req_ready stays 0. On out_ready=1 the next beat loads in the same cycle.
5. Owner 1 drops req_valid after 1 beat while reqs 0 and 3 are valid → req 3 is accepted in that same cycle (search from rr_ptr=2), followed by req 0.
6. enable dropped after owner 0 sent 1 of 4 beats → the output drains and no accepts occur for 5 cycles. On re-enable, owner 0 sends exactly 3 more beats before release.

Source files
------------

// File: rtl/rr_data_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready output stage.
// A winning requester keeps the stage for up to MAX_BURST consecutive beats.
module rr_data_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned ID_W     = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]          out_id,
    input  logic                     out_ready
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    w_rr_ptr_nxt;
    logic [ID_W-1:0]    r_owner;
    logic [ID_W-1:0]    w_owner_nxt;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]   w_beat_cnt_nxt;

    logic               w_can_load;
    logic               w_load;
    logic [ID_W-1:0]    w_win;
    logic [ID_W-1:0]    w_rel_ptr;
    logic [ID_W:0]      w_pick_idle;
    logic [ID_W:0]      w_pick_drop;
    logic [WIDTH-1:0]   w_data [NUM_REQ];

    // First valid requester at or above start, wrapping; MSB flags a hit.
    function automatic logic [ID_W:0] pick(input logic [NUM_REQ-1:0] valid,
                                           input logic [ID_W-1:0]    start);
        logic [ID_W:0] res;
        int unsigned   idx;
        res = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(start) + (NUM_REQ - 1 - k)) % NUM_REQ;
            if (valid[ID_W'(idx)]) begin
                res = {1'b1, ID_W'(idx)};
            end
        end
        return res;
    endfunction

    function automatic logic [ID_W-1:0] inc_ptr(input logic [ID_W-1:0] p);
        return (32'(p) == NUM_REQ - 1) ? '0 : p + ID_W'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_data[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    assign w_can_load  = enable && (!out_valid || out_ready);
    assign w_rel_ptr   = inc_ptr(r_owner);
    assign w_pick_idle = pick(req_valid, r_rr_ptr);
    assign w_pick_drop = pick(req_valid, w_rel_ptr);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Next-state, winner selection and load strobe
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_beat_cnt_nxt = r_beat_cnt;
        w_load         = 1'b0;
        w_win          = '0;

        case (r_state)
            S_IDLE: begin
                if (w_can_load && w_pick_idle[ID_W]) begin
                    w_load         = 1'b1;
                    w_win          = w_pick_idle[ID_W-1:0];
                    w_owner_nxt    = w_win;
                    w_beat_cnt_nxt = CNT_W'(1);
                    if (MAX_BURST == 1) begin
                        w_rr_ptr_nxt = inc_ptr(w_win);
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_state_nxt  = S_LOCKED;
                    end
                end
            end

            S_LOCKED: begin
                if (w_can_load) begin
                    if (req_valid[r_owner] && (r_beat_cnt < CNT_W'(MAX_BURST))) begin
                        w_load         = 1'b1;
                        w_win          = r_owner;
                        w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                        if (w_beat_cnt_nxt == CNT_W'(MAX_BURST)) begin
                            w_rr_ptr_nxt = w_rel_ptr;
                            w_state_nxt  = S_IDLE;
                        end
                    end else begin
                        // Owner gave up: release and re-arbitrate in the same cycle.
                        w_rr_ptr_nxt = w_rel_ptr;
                        w_state_nxt  = S_IDLE;
                        if (w_pick_drop[ID_W]) begin
                            w_load         = 1'b1;
                            w_win          = w_pick_drop[ID_W-1:0];
                            w_owner_nxt    = w_win;
                            w_beat_cnt_nxt = CNT_W'(1);
                            if (MAX_BURST == 1) begin
                                w_rr_ptr_nxt = inc_ptr(w_win);
                            end else begin
                                w_state_nxt  = S_LOCKED;
                            end
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Accept strobe is combinational and forced low while in reset
    always_comb begin
        req_ready = '0;
        if (w_load && rst_n) begin
            req_ready[w_win] = 1'b1;
        end
    end

    // Shared output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (w_load) begin
            out_valid <= 1'b1;
            out_data  <= w_data[w_win];
            out_id    <= w_win;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_data_arbiter.sv
// Scoreboard bench for rr_data_arbiter: directed producer queues, monitors compare each output transfer.
module tb_rr_data_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned IDW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*W-1:0]  req_data = '0;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [IDW-1:0]  out_id;
    logic            out_ready = 1'b0;

    logic [N-1:0]    req_valid2 = '0;
    logic [N*W-1:0]  req_data2 = {8'h33, 8'h22, 8'h11, 8'h00};
    logic [N-1:0]    req_ready2;
    logic            out_valid2;
    logic [W-1:0]    out_data2;
    logic [IDW-1:0]  out_id2;
    logic            enable2 = 1'b1;
    logic            out_ready2 = 1'b1;

    int              n_checks = 0;
    int              n_fail = 0;
    logic [W-1:0]    pq [N][$];
    logic [IDW+W-1:0] exp_q[$];
    logic [IDW+W-1:0] exp2_q[$];
    logic [N-1:0]    acc_cap = '0;

    always #5 clk = ~clk;

    rr_data_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_ready(out_ready)
    );

    rr_data_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable2),
        .req_valid(req_valid2), .req_data(req_data2), .req_ready(req_ready2),
        .out_valid(out_valid2), .out_data(out_data2), .out_id(out_id2),
        .out_ready(out_ready2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < int'(N); i++) begin
            req_valid[i]       = (pq[i].size() != 0);
            req_data[i*W +: W] = (pq[i].size() != 0) ? pq[i][0] : '0;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        acc_cap = req_ready;
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(N); i++) begin
            if (acc_cap[i] && pq[i].size() != 0) void'(pq[i].pop_front());
        end
        acc_cap = '0;
        refresh();
    endtask

    task automatic tick();
        at_neg();
        at_pos();
    endtask

    task automatic wait_out_valid(input string name);
        int k = 0;
        while (!out_valid && k < 20) begin tick(); k++; end
        check(name, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int  k = 0;
        logic busy;
        busy = 1'b1;
        while (busy && k < 60) begin
            busy = out_valid || (exp_q.size() != 0);
            for (int i = 0; i < int'(N); i++) if (pq[i].size() != 0) busy = 1'b1;
            if (busy) begin tick(); k++; end
        end
        check(name, 32'(busy), 32'd0);
    endtask

    // Scoreboard monitor for the MAX_BURST=4 instance
    always @(negedge clk) begin
        logic [IDW+W-1:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {22'd0, out_id, out_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("beat", {22'd0, out_id, out_data}, {22'd0, e});
            end
        end
        if (|req_ready) check("ready_onehot", 32'($onehot(req_ready) && ((req_ready & ~req_valid) == '0)), 32'd1);
    end

    // Scoreboard monitor for the MAX_BURST=2 instance
    always @(negedge clk) begin
        logic [IDW+W-1:0] e;
        if (rst_n && out_valid2 && out_ready2 && exp2_q.size() != 0) begin
            e = exp2_q.pop_front();
            check("beat2", {22'd0, out_id2, out_data2}, {22'd0, e});
        end
        if (|req_ready2) check("ready2_onehot", 32'($onehot(req_ready2) && ((req_ready2 & ~req_valid2) == '0)), 32'd1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int k;
        logic [W-1:0] d;

        refresh();
        repeat (3) @(posedge clk);
        at_neg();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        at_pos();
        rst_n = 1'b1; enable = 1'b1; out_ready = 1'b1;

        // Single requester 2, five beats across a burst-limit release
        for (int i = 1; i <= 5; i++) begin
            d = W'(i * 8'h11);
            pq[2].push_back(d);
            exp_q.push_back({2'd2, d});
        end
        refresh();
        wait_out_valid("t2_start");
        len = 0;
        while (out_valid && len < 20) begin len++; tick(); end
        check("t2_gapless_len", 32'(len), 32'd5);
        wait_drain("t2_drain");

        // Output stall holds 0xA5, next beat loads on the drain cycle
        out_ready = 1'b0;
        pq[1].push_back(8'hA5); pq[1].push_back(8'hB6);
        exp_q.push_back({2'd1, 8'hA5}); exp_q.push_back({2'd1, 8'hB6});
        refresh();
        wait_out_valid("t4_loaded");
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("t4_hold_data", 32'(out_data), 32'hA5);
            check("t4_hold_id", 32'(out_id), 32'd1);
            check("t4_hold_ready", 32'(req_ready), 32'd0);
            at_pos();
        end
        out_ready = 1'b1;
        at_neg();
        check("t4_reload", 32'(req_ready), 32'b0010);
        at_pos();
        wait_drain("t4_drain");

        // Owner 1 drops after one beat; 3 wins same cycle, then 0
        pq[1].push_back(8'hC1);
        exp_q.push_back({2'd1, 8'hC1}); exp_q.push_back({2'd3, 8'hC3}); exp_q.push_back({2'd0, 8'hC0});
        refresh();
        at_neg();
        check("t5_owner1", 32'(req_ready), 32'b0010);
        at_pos();
        pq[0].push_back(8'hC0); pq[3].push_back(8'hC3);
        refresh();
        at_neg();
        check("t5_same_cycle3", 32'(req_ready), 32'b1000);
        at_pos();
        at_neg();
        check("t5_then0", 32'(req_ready), 32'b0001);
        at_pos();
        wait_drain("t5_drain");

        // Reset while a beat is held, then enable gating mid-burst
        out_ready = 1'b0;
        pq[3].push_back(8'h77);
        refresh();
        wait_out_valid("t1_held");
        for (int i = 0; i < 6; i++) pq[0].push_back(8'hA0 + W'(i));
        pq[1].push_back(8'hB0); pq[1].push_back(8'hB1);
        refresh();
        at_neg();
        check("t1_pre_out_data", 32'(out_data), 32'h77);
        #2 rst_n = 1'b0;
        #1;
        check("t1_rst_out_valid", 32'(out_valid), 32'd0);
        check("t1_rst_out_data", 32'(out_data), 32'd0);
        check("t1_rst_out_id", 32'(out_id), 32'd0);
        check("t1_rst_req_ready", 32'(req_ready), 32'd0);
        at_pos();
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back({2'd0, 8'hA0 + W'(i)});
        exp_q.push_back({2'd1, 8'hB0}); exp_q.push_back({2'd1, 8'hB1});
        exp_q.push_back({2'd0, 8'hA4}); exp_q.push_back({2'd0, 8'hA5});
        at_neg();
        check("t1_first_grant0", 32'(req_ready), 32'b0001);
        at_pos();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            check("t6_disabled_ready", 32'(req_ready), 32'd0);
            at_pos();
        end
        check("t6_drained", 32'(out_valid), 32'd0);
        enable = 1'b1;
        wait_drain("t6_drain");

        // MAX_BURST=2 with all four requesters valid
        for (int i = 0; i < 10; i++) begin
            k = (i / 2) % 4;
            exp2_q.push_back({IDW'(k), W'(k * 8'h11)});
        end
        req_valid2 = 4'hF;
        k = 0;
        while (!out_valid2 && k < 20) begin tick(); k++; end
        for (int i = 0; i < 10; i++) begin
            check("t3_gapless", 32'(out_valid2), 32'd1);
            tick();
        end
        k = 0;
        while (exp2_q.size() != 0 && k < 20) begin tick(); k++; end
        check("t3_done", 32'(exp2_q.size()), 32'd0);
        req_valid2 = '0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
